// File: rtl/sum_chk_pkg.sv
// Shared types and widths for the sum checker: operand/sum widths, counter widths,
// checker state encoding and the reference-sum helper.
package sum_chk_pkg;

    localparam int OPW  = 6;
    localparam int SUMW = 7;
    localparam int ERRW = 8;
    localparam int CHKW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Carry is kept so that 63 + 63 compares as 126, not 62.
    function automatic logic [SUMW-1:0] exp_sum(input logic [OPW-1:0] a,
                                                input logic [OPW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with a build-time choice between saturating at all-ones and wrapping.
module sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_hold;

    assign w_hold = SATURATE && (&r_cnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && !w_hold) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sum_checker.sv
// Online checker for a registered 6-bit adder: predicts each sum one cycle ahead,
// compares in RUN, counts compares and mismatches, and halts at MAX_ERR mismatches.
module sum_checker
    import sum_chk_pkg::*;
#(
    parameter int MAX_ERR = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OPW-1:0]  a_in,
    input  logic [OPW-1:0]  b_in,
    input  logic [SUMW-1:0] sum_in,
    output logic            mismatch,
    output logic [ERRW-1:0] err_cnt,
    output logic [CHKW-1:0] chk_cnt,
    output logic            sticky_fail,
    output logic            halted,
    output state_t          dbg_state
);

    // Handshake: none. en is a level; a compare happens on every clock edge where
    // the checker is in RUN and en is high, using the sum predicted one cycle earlier.

    localparam int ERRW1 = ERRW + 1;
    localparam logic [ERRW1-1:0] MAX_ERR_C = ERRW1'(MAX_ERR);

    state_t            r_state;
    logic [SUMW-1:0]   r_exp_q;
    logic              r_mismatch;
    logic              r_sticky;
    logic              r_halted;

    logic              w_compare;
    logic              w_err_inc;
    logic              w_reach_max;
    logic [SUMW-1:0]   w_sum;

    assign w_sum     = exp_sum(a_in, b_in);
    assign w_compare = (r_state == ST_RUN) && en;
    assign w_err_inc = w_compare && (sum_in != r_exp_q);

    // Unsaturated look-ahead of err_cnt so HALT is entered on the same edge it updates.
    assign w_reach_max = w_compare &&
                         (({1'b0, err_cnt} + {{ERRW{1'b0}}, w_err_inc}) >= MAX_ERR_C);

    sat_counter #(.W(ERRW), .SATURATE(1'b1)) u_err_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_err_inc),
        .o_cnt (err_cnt)
    );

    sat_counter #(.W(CHKW), .SATURATE(1'b0)) u_chk_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_compare),
        .o_cnt (chk_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_exp_q    <= '0;
            r_mismatch <= 1'b0;
            r_sticky   <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_mismatch <= w_err_inc;
            if (w_err_inc) begin
                r_sticky <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    r_exp_q <= w_sum;
                    r_state <= en ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    r_exp_q <= w_sum;
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else if (w_reach_max) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!en) begin
                        r_state  <= ST_IDLE;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign mismatch    = r_mismatch;
    assign sticky_fail = r_sticky;
    assign halted      = r_halted;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_sum_checker.sv
// Randomised bench for sum_checker: two instances (MAX_ERR 8 and 255) share stimulus
// and are checked every cycle against a rule-level model, plus literal spot checks.
module tb_sum_checker;
    import sum_chk_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;
    localparam int M_HALT  = 3;

    typedef struct {
        int         st;
        logic [6:0] exp;
        int         err;
        int         chk;
        bit         sticky;
        bit         mis;
    } m_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] a_in;
    logic [5:0] b_in;
    logic [6:0] sum_in;

    logic       mis8, sticky8, halt8;
    logic [7:0] err8;
    logic [15:0] chk8;
    state_t     st8;
    logic       mis255, sticky255, halt255;
    logic [7:0] err255;
    logic [15:0] chk255;
    state_t     st255;

    int         checks;
    int         errors;
    bit         run_chk;
    logic [6:0] adder_q;
    m_t         m8;
    m_t         m255;

    sum_checker #(.MAX_ERR(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .sum_in(sum_in),
        .mismatch(mis8), .err_cnt(err8), .chk_cnt(chk8), .sticky_fail(sticky8),
        .halted(halt8), .dbg_state(st8)
    );

    sum_checker #(.MAX_ERR(255)) dut255 (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .sum_in(sum_in),
        .mismatch(mis255), .err_cnt(err255), .chk_cnt(chk255), .sticky_fail(sticky255),
        .halted(halt255), .dbg_state(st255)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic m_t model_reset();
        m_t m;
        m.st = M_IDLE; m.exp = 7'd0; m.err = 0; m.chk = 0; m.sticky = 1'b0; m.mis = 1'b0;
        return m;
    endfunction

    // One clock of the checker's rules, from the values present before the edge.
    function automatic m_t model_next(input m_t m, input int max_err, input logic e,
                                      input logic [5:0] a, input logic [5:0] b,
                                      input logic [6:0] s);
        m_t n;
        bit cmp;
        bit bad;
        n   = m;
        cmp = (m.st == M_RUN) && e;
        bad = cmp && (s != m.exp);
        n.mis = bad;
        if (cmp) n.chk = (m.chk + 1) % 65536;
        if (bad) begin
            n.err    = (m.err < 255) ? m.err + 1 : 255;
            n.sticky = 1'b1;
        end
        if (m.st == M_PRIME || m.st == M_RUN) n.exp = 7'(int'(a) + int'(b));
        case (m.st)
            M_IDLE:  if (e) n.st = M_PRIME;
            M_PRIME: n.st = e ? M_RUN : M_IDLE;
            M_RUN:   if (!e) n.st = M_IDLE; else if (cmp && n.err >= max_err) n.st = M_HALT;
            default: if (!e) n.st = M_IDLE;
        endcase
        return n;
    endfunction

    function automatic state_t to_state(input int st);
        case (st)
            M_PRIME: return ST_PRIME;
            M_RUN:   return ST_RUN;
            M_HALT:  return ST_HALT;
            default: return ST_IDLE;
        endcase
    endfunction

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_dut(input string tag, input m_t m, input logic mis,
                               input logic [7:0] err, input logic [15:0] chk,
                               input logic sticky, input logic halt, input state_t st);
        check({tag, ".mismatch"}, 32'(mis), 32'(m.mis));
        check({tag, ".err_cnt"}, 32'(err), 32'(m.err));
        check({tag, ".chk_cnt"}, 32'(chk), 32'(m.chk));
        check({tag, ".sticky_fail"}, 32'(sticky), 32'(m.sticky));
        check({tag, ".halted"}, 32'(halt), 32'(m.st == M_HALT));
        check({tag, ".state"}, 32'(st), 32'(to_state(m.st)));
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            compare_dut("d8", m8, mis8, err8, chk8, sticky8, halt8, st8);
            compare_dut("d255", m255, mis255, err255, chk255, sticky255, halt255, st255);
        end
    end

    // driver tasks: called at posedge+1, return at the next posedge+1
    task automatic cycle_ab(input logic e, input logic [5:0] a, input logic [5:0] b,
                            input int sel);
        m_t n8;
        m_t n255;
        en     = e;
        a_in   = a;
        b_in   = b;
        sum_in = (sel < 0) ? adder_q : 7'(sel);
        n8     = model_next(m8, 8, e, a, b, sum_in);
        n255   = model_next(m255, 255, e, a, b, sum_in);
        @(posedge clk);
        #1;
        adder_q = 7'(int'(a) + int'(b));
        m8      = n8;
        m255    = n255;
    endtask

    task automatic cycle_rand(input logic e, input int sel, input bit nonzero);
        logic [5:0] a;
        logic [5:0] b;
        a = 6'($urandom_range(nonzero ? 1 : 0, 63));
        b = 6'($urandom_range(0, 63));
        cycle_ab(e, a, b, sel);
    endtask

    task automatic async_reset();
        #2;
        rst  = 1'b1;
        m8   = model_reset();
        m255 = model_reset();
        #1;
        check("arst.mismatch", 32'(mis8), 0);
        check("arst.err_cnt", 32'(err8), 0);
        check("arst.chk_cnt", 32'(chk8), 0);
        check("arst.sticky_fail", 32'(sticky8), 0);
        check("arst.halted", 32'(halt8), 0);
        check("arst.d255_chk_cnt", 32'(chk255), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        checks  = 0;
        errors  = 0;
        run_chk = 1'b0;
        rst     = 1'b1;
        en      = 1'b0;
        a_in    = '0;
        b_in    = '0;
        sum_in  = '0;
        adder_q = '0;
        m8      = model_reset();
        m255    = model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.mismatch", 32'(mis8), 0);
        check("rst.err_cnt", 32'(err8), 0);
        check("rst.chk_cnt", 32'(chk8), 0);
        check("rst.sticky_fail", 32'(sticky8), 0);
        check("rst.halted", 32'(halt8), 0);
        rst     = 1'b0;
        run_chk = 1'b1;

        // 20 clean compares after IDLE and PRIME
        repeat (22) cycle_rand(1'b1, -1, 1'b0);
        cycle_rand(1'b0, -1, 1'b0);
        check("clean20.chk_cnt", 32'(chk8), 20);
        check("clean20.err_cnt", 32'(err8), 0);
        check("clean20.d255_chk_cnt", 32'(chk255), 20);

        // PRIME followed by a quick en drop: no compare
        cycle_rand(1'b1, -1, 1'b0);
        cycle_rand(1'b0, -1, 1'b0);
        cycle_rand(1'b0, -1, 1'b0);
        check("prime_abort.chk_cnt", 32'(chk8), 20);

        // carry boundary 63 + 63
        cycle_ab(1'b1, 6'd63, 6'd63, -1);
        cycle_ab(1'b1, 6'd63, 6'd63, -1);
        cycle_ab(1'b1, 6'd63, 6'd63, -1);
        check("carry126.mismatch", 32'(mis8), 0);
        cycle_ab(1'b1, 6'd63, 6'd63, 62);
        check("carry62.mismatch", 32'(mis8), 1);
        check("carry62.err_cnt", 32'(err8), 1);
        check("carry62.sticky_fail", 32'(sticky8), 1);
        check("carry62.chk_cnt", 32'(chk8), 22);
        cycle_rand(1'b1, -1, 1'b0);
        check("pulse_end.mismatch", 32'(mis8), 0);

        // two more mismatches, then reset mid-RUN with en held high
        cycle_rand(1'b1, int'(adder_q ^ 7'd1), 1'b0);
        cycle_rand(1'b1, int'(adder_q ^ 7'd64), 1'b0);
        check("pre_rst.err_cnt", 32'(err8), 3);
        async_reset();
        cycle_rand(1'b1, -1, 1'b0);
        cycle_rand(1'b1, -1, 1'b0);
        check("post_rst_prime.chk_cnt", 32'(chk8), 0);
        cycle_rand(1'b1, -1, 1'b0);
        check("post_rst_resume.chk_cnt", 32'(chk8), 1);

        // chk_cnt wrap after 65,535 clean compares
        guard = 0;
        while (m8.chk != 65535 && guard < 70000) begin
            cycle_rand(1'b1, -1, 1'b0);
            guard++;
        end
        check("wrap_pre.chk_cnt", 32'(chk8), 65535);
        cycle_rand(1'b1, -1, 1'b0);
        check("wrap.chk_cnt", 32'(chk8), 0);
        check("wrap.err_cnt", 32'(err8), 0);
        check("wrap.sticky_fail", 32'(sticky8), 0);
        check("wrap.halted", 32'(halt8), 0);
        cycle_rand(1'b0, -1, 1'b0);

        // forced-zero sums: halt at 8 and at 255
        cycle_rand(1'b1, -1, 1'b1);
        cycle_rand(1'b1, -1, 1'b1);
        repeat (8) cycle_rand(1'b1, 0, 1'b1);
        check("halt8.halted", 32'(halt8), 1);
        check("halt8.err_cnt", 32'(err8), 8);
        check("halt8.chk_cnt", 32'(chk8), 8);
        check("halt8.d255_halted", 32'(halt255), 0);
        repeat (292) cycle_rand(1'b1, 0, 1'b1);
        check("hold8.err_cnt", 32'(err8), 8);
        check("hold8.chk_cnt", 32'(chk8), 8);
        check("halt255.err_cnt", 32'(err255), 255);
        check("halt255.halted", 32'(halt255), 1);
        check("halt255.chk_cnt", 32'(chk255), 255);
        cycle_rand(1'b0, -1, 1'b0);
        check("unhalt.halted", 32'(halt8), 0);
        check("unhalt.sticky_fail", 32'(sticky8), 1);

        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_checker.md
SUM_CHECKER -- requirements
Module: sum_checker

Interface
REQ-001 Parameter MAX_ERR, default 8, means the mismatch count at which checking halts (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  check enable; level-sensitive.
REQ-005 a_in  input  6  operand A applied to the 6-bit adder under test.
REQ-006 b_in  input  6  operand B applied to the adder under test.
REQ-007 sum_in  input  7  registered sum returned by the adder under test, one cycle after its operands.
REQ-008 mismatch  output  1  one-cycle pulse on a compare failure.
REQ-009 err_cnt  output  8  mismatch count, saturating.
REQ-010 chk_cnt  output  16  compares performed, wrapping.
REQ-011 sticky_fail  output  1  set on the first mismatch since reset.
REQ-012 halted  output  1  high while in state HALT.

Function
REQ-013 States: IDLE, PRIME, RUN, HALT; encoding is implementation-defined.
REQ-014 IDLE -> PRIME when en=1; PRIME -> RUN after exactly one cycle; RUN -> IDLE when en=0; RUN -> HALT when err_cnt reaches MAX_ERR; HALT -> IDLE only when en=0.
REQ-015 Register exp_q <= a_in + b_in, zero-extended to 7 bits with carry kept, every cycle in PRIME and RUN; latency 1 cycle, matching the adder.
REQ-016 In RUN each cycle: compare sum_in against exp_q; chk_cnt increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-017 On inequality in RUN: mismatch=1 in the following cycle, err_cnt increments (saturating at 255), sticky_fail set.
REQ-018 No compare, count change, or mismatch in IDLE, PRIME or HALT.
REQ-019 When err_cnt reaches MAX_ERR, transition to HALT in the same cycle it is updated; halted=1 from the next cycle on.
REQ-020 en deasserted during PRIME returns to IDLE with no compare.
REQ-021 Counters and sticky_fail persist across IDLE/RUN cycles; only rst clears them.
REQ-022 Boundary: a_in=63, b_in=63 expects 126; the carry bit participates in the compare.

Reset
REQ-023 rst asynchronously forces state IDLE, exp_q=0, mismatch=0, err_cnt=0, chk_cnt=0, sticky_fail=0, halted=0.
REQ-024 rst asserted mid-RUN aborts immediately; after release the block waits in IDLE for en, then re-enters PRIME.

Structure
REQ-025 Shared package sum_chk_pkg holds the state typedef, operand width (6), sum width (7) and counter widths.
REQ-026 One sub-module sat_counter (parameterised width, saturate/wrap select), instantiated for err_cnt and chk_cnt.

Verification
REQ-027 en=1, model adder correct for 20 cycles of random operands -> chk_cnt=20, err_cnt=0, mismatch never high.
REQ-028 a_in=63, b_in=63, sum_in=126 one cycle later -> no mismatch; sum_in=62 -> mismatch pulse, err_cnt=1, sticky_fail=1.
REQ-029 MAX_ERR=8, sum_in forced to 0 with nonzero operands -> halted=1 after 8 compares, err_cnt stays 8, chk_cnt frozen.
REQ-030 MAX_ERR=255, continuous mismatches for 300 cycles -> err_cnt holds at 255 and halted=1.
REQ-031 rst pulsed mid-RUN with err_cnt=3 -> all outputs 0 asynchronously; en held high -> one PRIME cycle, then compares resume.
REQ-032 chk_cnt preloaded near wrap (65,535 clean compares) -> one more compare gives 0x0000 with no other side effects.
